acc_deserializer: RTL and testbench
===================================

# acc_deserializer

Width-adapting pack stage between the consumer unit's decoupled valid/ready output and the accelerator's consumer input in the cohort FIFO controller. It gathers `deserialization_ratio` consecutive `data_width`-bit words from the consumer stream and emits them as one wide, lane-packed accelerator word. It holds a one-packet accumulation buffer plus a one-entry output register, so it sustains full throughput under continuous backpressure-free flow.

## Interface

Parameters:
- `DataWidth`, default `fifo_ctrl_pkg::data_width`: width of one consumer word (one lane).
- `MaxRatio`, default 8: maximum lanes per output word; output width is `DataWidth*MaxRatio`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `deserialization_ratio`  in  16  requested words per packet; software-static but may change between packets.
- `flush`  in  1  synchronous pulse; discards a partial packet.
- `in_valid`  in  1  consumer word valid.
- `in_ready`  out  1  consumer word accepted when `in_valid && in_ready`.
- `in_data`  in  DataWidth  consumer word.
- `out_valid`  out  1  packed word valid.
- `out_ready`  in  1  accelerator accepts when `out_valid && out_ready`.
- `out_data`  out  DataWidth*MaxRatio  packed word; lane i = bits [i*DataWidth +: DataWidth].
- `out_lanes`  out  $clog2(MaxRatio+1)  number of valid lanes in `out_data`.
- `busy`  out  1  partial packet held or `out_valid` high.
- `pkt_count`  out  32  packets delivered (wraps modulo 2^32).

## Operation

- Effective ratio R: `deserialization_ratio`, with 0 treated as 1 and values above MaxRatio clamped to MaxRatio.
- R is sampled into `ratio_q` on the first accepted beat of each packet. While beat count `cnt == 0`, the combinational input value is used. R never changes mid-packet.
- On an accepted beat, `in_data` is written to lane `cnt` of the pack buffer and `cnt` increments.
- On the beat where `cnt == R-1` (the last beat):
  - The pack buffer, including this beat, is copied into the output register.
  - Lanes >= R are written as zero.
  - `out_lanes` <= R, `out_valid` <= 1, and `cnt` <= 0.
- The output register clears `out_valid` on `out_ready` unless a new last beat loads it in the same cycle. A simultaneous drain and load keeps `out_valid` at 1 with the new data.
- `in_ready = !(last_beat && out_valid && !out_ready)`. Non-last beats are always accepted.
- `pkt_count` increments on every output handshake.
- `flush`:
  - Sets `cnt` to 0 and zeroes the pack buffer.
  - Does not affect the output register.
  - A beat accepted in the same cycle as `flush` is dropped.
  - `flush` has priority over accumulation.
- The data path has no FSM beyond `cnt`. The states are, implicitly:
  - IDLE: `cnt==0`, `!out_valid`.
  - FILL: `cnt>0`.
  - HOLD: `out_valid`.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_lanes`=0, `busy`=0, `pkt_count`=0; `cnt`=0 and `ratio_q`=1 internally.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- Throughput: one packet per R cycles with `out_ready` held high. R=1 gives one word per cycle.
- `in_ready` depends combinationally on `out_ready`. `out_*` signals are registered outputs.
- Once `out_valid` is high, `out_data` and `out_lanes` stay stable until the handshake.
- An asynchronous reset mid-packet discards all state. No partial output is ever emitted.

## Structure

- Add to `fifo_ctrl_pkg`:
  - `deser_max_ratio` constant.
  - The lane count typedef.
  - The clamp function `eff_ratio(logic [15:0]) -> lane count`, shared with the serializer on the producer side.
- Sub-module `acc_out_reg`: a one-entry valid/ready skid register. It is reusable for the producer-side serializer.
- Instantiate inside `fifo_controller` between the consumer unit and the accelerator, using the `decoupled_vr_if` master/slave modports.

## Test plan

- **Ratio 4, continuous input:** `in_valid` held 1 with words 0x10..0x17 and `out_ready`=1. Expect 2 packets: lanes {0x10,0x11,0x12,0x13} then {0x14..0x17}. `out_lanes`=4, lanes 4..7 zero, `pkt_count`=2, no `in_ready` deassertion.
- **Backpressure:** R=2 with `out_ready`=0. Expect the 1st packet to load, the 3rd beat to be accepted, and `in_ready`=0 on the 4th beat until `out_ready` rises. `out_data` is unchanged while stalled.
- **Clamping:** ratio=0 produces one packet per word with `out_lanes`=1. Ratio=20 with MaxRatio=8 produces `out_lanes`=8.
- **Ratio change mid-packet:** ratio changes from 3 to 2 after the 1st beat. The current packet still takes 3 beats, and the next packet takes 2.
- **Flush:** after 2 beats of R=4, a `flush` pulse, then 4 new beats. Expect one packet containing only the 4 new words.
- **Reset mid-packet:** assert `rst_n`=0 asynchronously after 3 beats of R=4. All outputs return to reset values immediately, and a subsequent 4 beats produce exactly one packet.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared types, constants and helpers for the cohort FIFO controller.
// Contents used by the width adapters on the accelerator side:
//   data_width       - width of one consumer/producer word (one lane)
//   deser_max_ratio  - maximum lanes per packed accelerator word
//   lane_cnt_t       - lane count sized for deser_max_ratio
//   eff_ratio()      - clamps a software ratio register to a usable lane count
package fifo_ctrl_pkg;

  localparam int data_width      = 8;
  localparam int deser_max_ratio = 8;
  localparam int lane_cnt_width  = $clog2(deser_max_ratio + 1);

  typedef logic [lane_cnt_width-1:0] lane_cnt_t;

  // Effective lane count for a software ratio value: 0 behaves as 1 (a
  // zero-length packet would never complete) and anything above the
  // instance's lane capacity saturates at that capacity. The result stays
  // 16 bits wide so instances with a non-default capacity can share it.
  function automatic logic [15:0] eff_ratio(input logic [15:0] ratio,
                                            input logic [15:0] max_ratio);
    logic [15:0] r;
    r = ratio;
    if (r == 16'd0) begin
      r = 16'd1;
    end else if (r > max_ratio) begin
      r = max_ratio;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_out_reg.sv
// acc_out_reg
// One-entry valid/ready output register. A load always wins over a drain in
// the same cycle, so back-to-back packets stream without a bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture load_data/load_lanes and raise valid
//   load_data/_lanes    word and lane count to capture
//   valid, ready        downstream handshake
//   data, lanes         registered word and lane count (stable while valid)
//   can_load            entry is empty or draining this cycle
module acc_out_reg #(
  parameter int Width = 64,
  parameter int LaneW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic [LaneW-1:0] load_lanes,
  output logic             valid,
  input  logic             ready,
  output logic [Width-1:0] data,
  output logic [LaneW-1:0] lanes,
  output logic             can_load
);

  logic             valid_reg;
  logic [Width-1:0] data_reg;
  logic [LaneW-1:0] lanes_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      lanes_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      lanes_reg <= load_lanes;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign data     = data_reg;
  assign lanes    = lanes_reg;
  assign can_load = !valid_reg || ready;

endmodule

// File: rtl/acc_deserializer.sv
// acc_deserializer
// Packs R consecutive DataWidth-bit consumer words into one lane-packed
// accelerator word (lane i = bits [i*DataWidth +: DataWidth]); lanes >= R are
// zero. R is the clamped deserialization_ratio, frozen for the whole packet.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   deserialization_ratio      requested words per packet
//   flush                      drops the partial packet (and any beat this cycle)
//   in_valid/in_ready/in_data  consumer word stream
//   out_valid/out_ready        packed word handshake
//   out_data, out_lanes        packed word and its number of valid lanes
//   busy                       partial packet held or output pending
//   pkt_count                  delivered packets, wraps at 2^32
module acc_deserializer
  import fifo_ctrl_pkg::*;
#(
  parameter int DataWidth = data_width,
  parameter int MaxRatio  = deser_max_ratio
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [15:0]                     deserialization_ratio,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DataWidth-1:0]            in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DataWidth*MaxRatio-1:0]   out_data,
  output logic [$clog2(MaxRatio+1)-1:0]   out_lanes,
  output logic                            busy,
  output logic [31:0]                     pkt_count
);

  localparam int LaneW = $clog2(MaxRatio + 1);
  localparam int OutW  = DataWidth * MaxRatio;

  logic [LaneW-1:0] cnt_reg, cnt_next;
  logic [LaneW-1:0] ratio_q_reg;
  logic [15:0]      eff_r;
  logic [15:0]      cur_ratio;
  logic [OutW-1:0]  load_data;
  logic [31:0]      pkt_count_reg;
  logic             last_beat, accept, load, can_load;

  assign eff_r = eff_ratio(deserialization_ratio, 16'(MaxRatio));

  // The first beat of a packet sees the live ratio; later beats use the
  // value frozen on that first beat.
  assign cur_ratio = (cnt_reg == '0) ? eff_r : 16'(ratio_q_reg);
  assign last_beat = (16'(cnt_reg) == cur_ratio - 16'd1);

  // Only a completing beat needs room in the output register.
  assign in_ready = !(last_beat && !can_load);
  assign accept   = in_valid && in_ready;
  assign load     = accept && last_beat && !flush;

  always_comb begin
    cnt_next = cnt_reg;
    if (flush) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = last_beat ? '0 : cnt_reg + LaneW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      ratio_q_reg <= LaneW'(1);
    end else begin
      cnt_reg <= cnt_next;
      if (accept && !flush && cnt_reg == '0) begin
        ratio_q_reg <= eff_r[LaneW-1:0];
      end
    end
  end

  // Per-lane pack buffer. The output word is assembled from the lanes
  // already captured plus the current beat, so the last beat never has to
  // pass through the buffer first.
  genvar gi;
  generate
    for (gi = 0; gi < MaxRatio; gi++) begin : g_lane
      logic [DataWidth-1:0] lane_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= '0;
        end else if (flush) begin
          lane_reg <= '0;
        end else if (accept && cnt_reg == LaneW'(gi)) begin
          lane_reg <= in_data;
        end
      end

      assign load_data[gi*DataWidth +: DataWidth] =
        (cnt_reg == LaneW'(gi)) ? in_data :
        (16'(gi) < cur_ratio)   ? lane_reg : '0;
    end
  endgenerate

  acc_out_reg #(
    .Width (OutW),
    .LaneW (LaneW)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .load_lanes (cur_ratio[LaneW-1:0]),
    .valid      (out_valid),
    .ready      (out_ready),
    .data       (out_data),
    .lanes      (out_lanes),
    .can_load   (can_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      pkt_count_reg <= pkt_count_reg + 32'd1;
    end
  end

  assign pkt_count = pkt_count_reg;
  assign busy      = (cnt_reg != '0) || out_valid;

endmodule

// File: tb/tb_acc_deserializer.sv
module tb_acc_deserializer;

  localparam int DW = 8;
  localparam int MR = 8;
  localparam int OW = DW * MR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   ratio = 16'd1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [3:0]    out_lanes;
  logic          busy;
  logic [31:0]   pkt_count;

  always #5 clk = ~clk;

  acc_deserializer #(
    .DataWidth (DW),
    .MaxRatio  (MR)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .deserialization_ratio (ratio),
    .flush                 (flush),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_lanes             (out_lanes),
    .busy                  (busy),
    .pkt_count             (pkt_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_words[$];     // words of the packet being gathered
  int          m_r     = 1;    // lane count frozen for that packet
  bit          m_ov    = 1'b0;
  logic [63:0] m_data  = '0;
  int          m_lanes = 0;
  int unsigned m_pkts  = 0;

  logic [63:0] log_data[$];    // words seen at output handshakes
  int          log_lanes[$];

  function automatic int eff(input logic [15:0] r);
    if (r == 16'd0) return 1;
    if (r > 16'(MR)) return MR;
    return int'(r);
  endfunction

  function automatic int cur_r();
    return (m_words.size() == 0) ? eff(ratio) : m_r;
  endfunction

  function automatic bit m_ready();
    return !(m_ov && !out_ready && (m_words.size() + 1 == cur_r()));
  endfunction

  initial begin : model
    int r;
    bit acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_words.delete();
        m_r    = 1;
        m_ov   = 1'b0;
        m_pkts = 0;
      end else begin
        r   = cur_r();
        acc = in_valid && m_ready();
        if (m_ov && out_ready) begin
          m_pkts++;
          m_ov = 1'b0;
        end
        if (flush) begin
          m_words.delete();
        end else if (acc) begin
          if (m_words.size() == 0) m_r = r;
          m_words.push_back(in_data);
          if (m_words.size() == m_r) begin
            m_data = '0;
            foreach (m_words[k]) m_data[k*8 +: 8] = m_words[k];
            m_lanes = m_r;
            m_ov    = 1'b1;
            m_words.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_ov || (m_words.size() != 0));
      chk("pkt_count", pkt_count, m_pkts);
      if (m_ov) begin
        chk("out_data", out_data, m_data);
        chk("out_lanes", out_lanes, m_lanes);
      end
      if (out_valid && out_ready) begin
        log_data.push_back(out_data);
        log_lanes.push_back(int'(out_lanes));
        $display("pkt: data=%016h lanes=%0d count=%0d", out_data, out_lanes, pkt_count);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy,
                     input logic [15:0] r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    ratio     = r;
    flush     = f;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b1, ratio, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lanes", out_lanes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    rst_n = 1'b1;
    idle(2);

    // Ratio 4, continuous input
    log_data.delete(); log_lanes.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(16 + i), 1'b1, 16'd4, 1'b0);
    idle(3);
    chk("s1_npkt", log_data.size(), 2);
    chk("s1_p0", log_data[0], 64'h0000_0000_1312_1110);
    chk("s1_p1", log_data[1], 64'h0000_0000_1716_1514);
    chk("s1_lanes", log_lanes[1], 4);
    chk("s1_count", pkt_count, 2);

    // Backpressure, R=2
    log_data.delete(); log_lanes.delete();
    cyc(1'b1, 8'h20, 1'b0, 16'd2, 1'b0);
    cyc(1'b1, 8'h21, 1'b0, 16'd2, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 16'd2, 1'b0);
    in_valid = 1'b1; in_data = 8'h23; out_ready = 1'b0;
    #1;
    chk("s2_stall_ready0", in_ready, 0);
    chk("s2_stall_data0", out_data, 64'h2120);
    @(posedge clk); #2;
    chk("s2_stall_ready1", in_ready, 0);
    chk("s2_stall_data1", out_data, 64'h2120);
    chk("s2_stall_valid", out_valid, 1);
    @(posedge clk); #2;
    cyc(1'b1, 8'h23, 1'b1, 16'd2, 1'b0);
    idle(3);
    chk("s2_npkt", log_data.size(), 2);
    chk("s2_p0", log_data[0], 64'h2120);
    chk("s2_p1", log_data[1], 64'h2322);
    chk("s2_count", pkt_count, 4);

    // Clamping: 0 -> 1 lane, 20 -> 8 lanes
    log_data.delete(); log_lanes.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(48 + i), 1'b1, 16'd0, 1'b0);
    idle(2);
    chk("s3_npkt_r0", log_data.size(), 3);
    chk("s3_p2", log_data[2], 64'h32);
    chk("s3_lanes_r0", log_lanes[0], 1);
    log_data.delete(); log_lanes.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(64 + i), 1'b1, 16'd20, 1'b0);
    idle(3);
    chk("s3_npkt_r20", log_data.size(), 1);
    chk("s3_p_r20", log_data[0], 64'h4746_4544_4342_4140);
    chk("s3_lanes_r20", log_lanes[0], 8);
    chk("s3_count", pkt_count, 8);

    // Ratio change mid-packet
    log_data.delete(); log_lanes.delete();
    cyc(1'b1, 8'h50, 1'b1, 16'd3, 1'b0);
    cyc(1'b1, 8'h51, 1'b1, 16'd2, 1'b0);
    cyc(1'b1, 8'h52, 1'b1, 16'd2, 1'b0);
    cyc(1'b1, 8'h53, 1'b1, 16'd2, 1'b0);
    cyc(1'b1, 8'h54, 1'b1, 16'd2, 1'b0);
    idle(3);
    chk("s4_npkt", log_data.size(), 2);
    chk("s4_p0", log_data[0], 64'h52_5150);
    chk("s4_l0", log_lanes[0], 3);
    chk("s4_p1", log_data[1], 64'h5453);
    chk("s4_l1", log_lanes[1], 2);

    // Flush after 2 beats (the beat offered with flush is dropped)
    log_data.delete(); log_lanes.delete();
    cyc(1'b1, 8'h60, 1'b1, 16'd4, 1'b0);
    cyc(1'b1, 8'h61, 1'b1, 16'd4, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(98 + i), 1'b1, 16'd4, 1'b0);
    idle(3);
    chk("s5_npkt", log_data.size(), 1);
    chk("s5_p0", log_data[0], 64'h6564_6362);
    chk("s5_count", pkt_count, 11);

    // Asynchronous reset mid-packet
    log_data.delete(); log_lanes.delete();
    cyc(1'b1, 8'h70, 1'b1, 16'd4, 1'b0);
    cyc(1'b1, 8'h71, 1'b1, 16'd4, 1'b0);
    cyc(1'b1, 8'h72, 1'b1, 16'd4, 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_out_valid", out_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_in_ready", in_ready, 1);
    chk("s6_rst_pkt_count", pkt_count, 0);
    chk("s6_rst_out_data", out_data, 0);
    chk("s6_rst_out_lanes", out_lanes, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(128 + i), 1'b1, 16'd4, 1'b0);
    idle(3);
    chk("s6_npkt", log_data.size(), 1);
    chk("s6_p0", log_data[0], 64'h8382_8180);
    chk("s6_count", pkt_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
